// File: rtl/num_char_pkg.sv
// Shared definitions for the ASCII <-> number conversion blocks:
// parser state encodings, ASCII constants, result status codes and
// character classification helpers.
package num_char_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NUM   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] ZERO  = 8'h30;
  localparam logic [7:0] NINE  = 8'h39;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] NUL   = 8'h00;
  localparam logic [7:0] MINUS = 8'h2D;

  localparam logic [1:0] ERR_OK  = 2'd0;
  localparam logic [1:0] ERR_OVF = 2'd1;
  localparam logic [1:0] ERR_BAD = 2'd2;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= ZERO) && (c <= NINE);
  endfunction

  function automatic logic is_term(input logic [7:0] c);
    return (c == SPACE) || (c == CR) || (c == LF) || (c == NUL);
  endfunction

endpackage

// File: rtl/dec_mac10.sv
// Combinational decimal multiply-accumulate: acc*10 + digit, computed
// with four guard bits so the true product is never lost, then compared
// against the caller's limit. On overflow the result is clamped.
module dec_mac10 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [3:0]       digit_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic [WIDTH-1:0] acc_o,
  output logic             ovf_o
);

  logic [WIDTH+3:0] acc_wide;
  logic [WIDTH+3:0] prod;

  // acc*10 as (acc<<3)+(acc<<1), plus the new digit, then saturate
  always_comb begin
    acc_wide = {4'b0000, acc_i};
    prod     = (acc_wide << 3) + (acc_wide << 1) + {{WIDTH{1'b0}}, digit_i};
    ovf_o    = prod > {4'b0000, limit_i};
    acc_o    = ovf_o ? limit_i : prod[WIDTH-1:0];
  end

endmodule

// File: rtl/char2num.sv
// Streaming ASCII-decimal parser. Digits accumulate into a binary value;
// a terminator (space, CR, LF, NUL) publishes the value with a status
// code as a one-cycle valid_o pulse. Any other character poisons the
// field until its terminator.
// Optional feature macro: CHAR2NUM_SIGN_EN enables a leading '-' and
// two's-complement output with signed saturation.
module char2num
  import num_char_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       char_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] num_o,
  output logic [1:0]       err_o,
  output logic             valid_o
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             neg_q, neg_d;
  logic             nodig_q, nodig_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic [1:0]       err_q, err_d;

  logic             accept;
  logic             c_digit;
  logic             c_term;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] mac_acc;
  logic             mac_ovf;
  logic [WIDTH-1:0] signed_acc;

  dec_mac10 #(.WIDTH(WIDTH)) u_mac (
    .acc_i   (acc_q),
    .digit_i (char_i[3:0]),
    .limit_i (limit),
    .acc_o   (mac_acc),
    .ovf_o   (mac_ovf)
  );

  // Magnitude limit: full unsigned range, or asymmetric signed range
  always_comb begin
`ifdef CHAR2NUM_SIGN_EN
    limit = neg_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
    limit = '1;
`endif
    signed_acc = neg_q ? (~acc_q + 1'b1) : acc_q;
  end

  // Parser FSM: classify the accepted character and update field state
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    neg_d   = neg_q;
    nodig_d = nodig_q;
    num_d   = num_q;
    err_d   = err_q;
    accept  = valid_i && (state_q != S_DONE);
    c_digit = is_digit(char_i);
    c_term  = is_term(char_i);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (c_digit) begin
            acc_d   = {{(WIDTH-4){1'b0}}, char_i[3:0]};
            ovf_d   = 1'b0;
            neg_d   = 1'b0;
            nodig_d = 1'b0;
            state_d = S_NUM;
          end else if (c_term) begin
            state_d = S_IDLE;
`ifdef CHAR2NUM_SIGN_EN
          end else if (char_i == MINUS) begin
            acc_d   = '0;
            ovf_d   = 1'b0;
            neg_d   = 1'b1;
            nodig_d = 1'b1;
            state_d = S_NUM;
`endif
          end else begin
            state_d = S_FLUSH;
          end
        end
      end
      S_NUM: begin
        if (accept) begin
          if (c_digit) begin
            acc_d   = mac_acc;
            ovf_d   = ovf_q | mac_ovf;
            nodig_d = 1'b0;
          end else if (c_term) begin
            state_d = S_DONE;
            if (nodig_q) begin
              num_d = '0;
              err_d = ERR_BAD;
            end else if (ovf_q) begin
              num_d = signed_acc;
              err_d = ERR_OVF;
            end else begin
              num_d = signed_acc;
              err_d = ERR_OK;
            end
          end else begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (accept && c_term) begin
          state_d = S_DONE;
          num_d   = '0;
          err_d   = ERR_BAD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
      nodig_q <= 1'b0;
      num_q   <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      neg_q   <= neg_d;
      nodig_q <= nodig_d;
      num_q   <= num_d;
      err_q   <= err_d;
    end
  end

  assign ready_o = (state_q != S_DONE);
  assign valid_o = (state_q == S_DONE);
  assign num_o   = num_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_char2num.sv
// Directed bench for char2num (unsigned default build). Expected results
// are queued when a field is driven and popped when valid_o pulses.
module tb_char2num;

  localparam logic [7:0] C_SP  = 8'h20;
  localparam logic [7:0] C_CR  = 8'h0D;
  localparam logic [7:0] C_LF  = 8'h0A;
  localparam logic [7:0] C_NUL = 8'h00;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  char_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] num_o;
  logic [1:0]  err_o;
  logic        valid_o;

  int check_cnt = 0;
  int error_cnt = 0;
  int pulse_cnt = 0;
  logic [33:0] sb_q[$];
  logic [33:0] sb_exp;

  always #5 CLK = ~CLK;

  char2num #(.WIDTH(32)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .char_i  (char_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .num_o   (num_o),
    .err_o   (err_o),
    .valid_o (valid_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    assert (obs === exp) else begin
      error_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_result(input logic [31:0] num, input logic [1:0] err);
    sb_q.push_back({err, num});
  endtask

  // Drive one character, optionally after a random idle gap, and hold it
  // until the DUT accepts it on a rising edge.
  task automatic send_char(input logic [7:0] c, input int max_gap);
    int gap;
    int waited;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    for (int i = 0; i < gap; i++) begin
      valid_i = 1'b0;
      char_i  = 8'h78;
      @(posedge CLK); #1;
    end
    char_i  = c;
    valid_i = 1'b1;
    waited  = 0;
    while (ready_o !== 1'b1 && waited < 8) begin
      @(posedge CLK); #1;
      waited++;
    end
    if (waited >= 8) check("ready_timeout", 64'(ready_o), 64'd1);
    @(posedge CLK); #1;
  endtask

  task automatic apply_stimulus(input string body, input logic [7:0] term, input int max_gap);
    for (int i = 0; i < body.len(); i++) send_char(body[i], max_gap);
    send_char(term, max_gap);
    valid_i = 1'b0;
  endtask

  // Scoreboard side: every valid_o cycle must match the oldest expectation
  always @(negedge CLK) begin
    if (valid_o === 1'b1) begin
      pulse_cnt++;
      check("result_expected", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        sb_exp = sb_q.pop_front();
        check("num_o", 64'(num_o), 64'(sb_exp[31:0]));
        check("err_o", 64'(err_o), 64'(sb_exp[33:32]));
      end
    end
  end

  initial begin
    int waited;
    RST     = 1'b1;
    valid_i = 1'b0;
    char_i  = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    check("reset_ready", 64'(ready_o), 64'd1);
    check("reset_valid", 64'(valid_o), 64'd0);
    check("reset_num", 64'(num_o), 64'd0);
    check("reset_err", 64'(err_o), 64'd0);

    expect_result(32'h0000_04D2, 2'd0);
    apply_stimulus("1234", C_CR, 0);
    expect_result(32'hFFFF_FFFF, 2'd0);
    apply_stimulus("4294967295", C_SP, 0);
    expect_result(32'hFFFF_FFFF, 2'd1);
    apply_stimulus("4294967296", C_SP, 0);
    expect_result(32'hFFFF_FFFF, 2'd1);
    apply_stimulus("99999999999", C_LF, 0);

    expect_result(32'd0, 2'd2);
    apply_stimulus("12a4", C_LF, 0);
    expect_result(32'd7, 2'd0);
    apply_stimulus("7", C_LF, 0);

    apply_stimulus("   ", C_LF, 0);
    send_char(C_NUL, 0);
    valid_i = 1'b0;
    expect_result(32'd5, 2'd0);
    apply_stimulus("  0005", C_NUL, 3);

    expect_result(32'd9, 2'd0);
    expect_result(32'd8, 2'd0);
    send_char(8'h39, 0);
    send_char(C_LF, 0);
    check("stall1_ready", 64'(ready_o), 64'd0);
    check("stall1_valid", 64'(valid_o), 64'd1);
    char_i = 8'h38;
    @(posedge CLK); #1;
    check("stall1_ready_back", 64'(ready_o), 64'd1);
    send_char(8'h38, 0);
    send_char(C_LF, 0);
    check("stall2_ready", 64'(ready_o), 64'd0);
    valid_i = 1'b0;
    @(posedge CLK); #1;
    check("stall2_ready_back", 64'(ready_o), 64'd1);

    send_char(8'h31, 0);
    send_char(8'h32, 0);
    send_char(8'h33, 0);
    valid_i = 1'b0;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check("mid_reset_num", 64'(num_o), 64'd0);
    expect_result(32'd4, 2'd0);
    apply_stimulus("4", C_LF, 0);

    repeat (3) @(posedge CLK);
    #1;
    check("hold_num", 64'(num_o), 64'd4);
    check("hold_valid", 64'(valid_o), 64'd0);

    waited = 0;
    while (sb_q.size() != 0 && waited < 50) begin
      @(posedge CLK); #1;
      waited++;
    end
    check("pending_results", 64'(sb_q.size()), 64'd0);
    check("pulse_count", 64'(pulse_cnt), 64'd10);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
    $finish;
  end

endmodule
